// File: rtl/region_decoder.sv
// region_decoder: registered base/mask address decoder and bus-cycle sequencer with wait states, ack and timeout
module region_decoder #(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] BASE = {32'h04010000, 32'h04000000, 32'h00000000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] MASK = {32'hFFFFFFF0, 32'hFFFF0000, 32'hFC000000},
  parameter logic [NUM_REGIONS*4-1:0] WAIT = {4'd0, 4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0] ACK_MODE = 3'b100,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   we,
  input  logic [NUM_REGIONS-1:0] slave_ack,
  output logic [NUM_REGIONS-1:0] select,
  output logic [ADDR_WIDTH-1:0]  addr_q,
  output logic                   we_q,
  output logic                   ready,
  output logic                   error,
  output logic                   busy
);
  localparam int CW = $clog2(TIMEOUT) > 4 ? $clog2(TIMEOUT) : 4;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_REGIONS-1:0] sel_q, hot;
  logic [3:0] wt;
  logic hit, mode_d, mode_q, ack_hit;
  assign ack_hit = |(slave_ack & sel_q);
  assign select = sel_q;
  assign ready = (state == DONE) || (state == ERR);
  assign error = state == ERR;
  assign busy = state != IDLE;
  // window decode, scanned high to low so the lowest matching index wins
  always_comb begin
    hit = 1'b0;
    hot = '0;
    wt = '0;
    mode_d = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if ((addr & MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        hot = '0;
        hot[i] = 1'b1;
        wt = WAIT[i*4 +: 4];
        mode_d = ACK_MODE[i];
      end
  end
  // next state and counter: wait-state countdown or ack wait with timeout count-up
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (req) begin
        state_n = hit ? ACCESS : ERR;
        cnt_n = (hit && !mode_d) ? CW'(wt) : '0;
      end
      ACCESS: if (mode_q) begin
        if (ack_hit) state_n = DONE;
        else if (cnt == CW'(TIMEOUT - 1)) state_n = ERR;
        else cnt_n = cnt + 1'b1;
      end else begin
        if (cnt == '0) state_n = DONE;
        else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register; request fields latched on acceptance, select held through DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sel_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel_q <= (state_n == ACCESS || state_n == DONE) ? (state == IDLE ? hot : sel_q) : '0;
      if (state == IDLE && req) begin
        addr_q <= addr;
        we_q <= we;
        mode_q <= mode_d;
      end
    end
  end
endmodule
